// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: arbitration, operand capture and per-requester flag contexts.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default build is round-robin.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] op0,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       req1,
    input  logic [3:0] op1,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       res_vld0,
    output logic       res_vld1,
    output logic [7:0] res_data,
    output logic [7:0] res_flags,
    output logic [7:0] flags0,
    output logic [7:0] flags1,
    output logic       busy,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic [7:0] alu_flags_in,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_flags_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       owner;
    logic       pick1;
    logic       grant;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        pick1 = !req0 && req1;
    end
`else
    logic last;

    // On a tie the requester not granted last wins.
    always_comb begin
        pick1 = req1;
        if (req0 && req1) begin
            pick1 = !last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (grant) begin
            last <= pick1;
        end
    end
`endif

    assign grant    = (state == IDLE) && (req0 || req1);
    assign gnt0     = grant && !pick1;
    assign gnt1     = grant && pick1;
    assign res_vld0 = (state == RESP) && !owner;
    assign res_vld1 = (state == RESP) && owner;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            res_data     <= 8'h00;
            res_flags    <= 8'h00;
            flags0       <= 8'h00;
            flags1       <= 8'h00;
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_op       <= 4'h0;
            alu_flags_in <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state        <= EXEC;
                        owner        <= pick1;
                        alu_op       <= pick1 ? op1 : op0;
                        alu_a        <= pick1 ? a1 : a0;
                        alu_b        <= pick1 ? b1 : b0;
                        alu_flags_in <= pick1 ? flags1 : flags0;
                    end
                end
                EXEC: begin
                    state     <= RESP;
                    res_data  <= alu_result;
                    res_flags <= alu_flags_out;
                    if (owner) begin
                        flags1 <= alu_flags_out;
                    end else begin
                        flags0 <= alu_flags_out;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
